// File: rtl/mod_mul_pkg.sv
// Shared secp256k1 field parameters and FSM state encoding for the field
// arithmetic blocks (multiplier and inverter).
package mod_mul_pkg;

    localparam int SECP_WIDTH = 256;

    // secp256k1 prime: 2^256 - 2^32 - 977
    localparam logic [SECP_WIDTH-1:0] SECP_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREP   = 2'd1,
        ST_LOOP   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/mod_mul_step.sv
// One MSB-first interleaved multiply-and-reduce step:
// acc_next = (2*acc + (b_bit ? a : 0)) mod P, given acc < P and a < P.
module mod_mul_step
    import mod_mul_pkg::*;
#(
    parameter int              WIDTH = SECP_WIDTH,
    parameter logic [WIDTH-1:0] P    = SECP_P
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] a,
    input  logic             b_bit,
    output logic [WIDTH-1:0] acc_next
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH+1:0] p_ext;
    logic [WIDTH+1:0] t_sum;
    logic [WIDTH+1:0] t_red1;
    logic [WIDTH+1:0] t_red2;

    // Gate the multiplicand with the current multiplier bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gate
            assign addend[gi] = a[gi] & b_bit;
        end
    endgenerate

    assign p_ext = {2'b00, P};

    // Double, add, then two conditional subtracts bring t (< 3P) back below P.
    always_comb begin
        t_sum    = {1'b0, acc, 1'b0} + {2'b00, addend};
        t_red1   = (t_sum  >= p_ext) ? (t_sum  - p_ext) : t_sum;
        t_red2   = (t_red1 >= p_ext) ? (t_red1 - p_ext) : t_red1;
        acc_next = t_red2[WIDTH-1:0];
    end

endmodule

// File: rtl/mod_mul.sv
// Bit-serial modular multiplier over the secp256k1 field: product = (a*b) mod P.
// One multiplier bit per clock, fixed latency of WIDTH+2 cycles from start
// acceptance to the done pulse.
module mod_mul
    import mod_mul_pkg::*;
#(
    parameter int              WIDTH = SECP_WIDTH,
    parameter logic [WIDTH-1:0] P    = SECP_P
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic             done,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] acc_next;

    mod_mul_step #(
        .WIDTH (WIDTH),
        .P     (P)
    ) u_step (
        .acc      (acc_reg),
        .a        (a_reg),
        .b_bit    (b_reg[count_reg]),
        .acc_next (acc_next)
    );

    // FSM: capture operands, reduce a once, walk b MSB-first, publish result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            count_reg <= '0;
            product   <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done <= 1'b0;
                    // busy drops the edge after done unless a new request
                    // is taken back-to-back.
                    busy <= start;
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        state_reg <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    // a < 2^WIDTH < 2P, so a single subtract fully reduces it.
                    if (a_reg >= P) begin
                        a_reg <= a_reg - P;
                    end
                    acc_reg   <= '0;
                    count_reg <= CNT_W'(WIDTH - 1);
                    state_reg <= ST_LOOP;
                end
                ST_LOOP: begin
                    acc_reg <= acc_next;
                    if (count_reg == '0) begin
                        state_reg <= ST_FINISH;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                    end
                end
                ST_FINISH: begin
                    product   <= acc_reg;
                    done      <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
